// File: rtl/enigma_step_ctrl.sv
// rtl/enigma_step_ctrl.sv - Enigma rotor stepping and seven-pass datapath sequencer
module enigma_step_ctrl #(
    parameter int NOTCH0 = 21,
    parameter int NOTCH1 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [4:0]  in_char,
    output logic        in_ready,
    output logic        out_valid,
    output logic [4:0]  out_char,
    input  logic        out_ready,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [4:0]  cfg_data,
    output logic [14:0] pos_out,
    output logic [1:0]  rot_sel,
    output logic        rot_dir,
    output logic [4:0]  rot_in,
    input  logic [4:0]  rot_out
);

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, REF, B2, B1, B0, DONE
    } state_t;

    state_t state, state_next;

    logic [4:0] pos0, pos1, pos2;
    logic [4:0] data;
    logic [4:0] data_next;
    logic [4:0] cur_pos;
    logic [4:0] r_adj;
    logic [4:0] cfg_val;
    logic       accept;
    logic       cfg_write;
    logic       bypass;
    logic       in_pass;
    logic       step_mid;
    logic       step_slow;

    // (a + b) mod 26 for operands already reduced to 0..25
    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    // (r - p) mod 26 for operands already reduced to 0..25
    function automatic logic [4:0] sub26(input logic [4:0] r, input logic [4:0] p);
        logic [5:0] s;
        if (r >= p) s = {1'b0, r} - {1'b0, p};
        else        s = {1'b0, r} + 6'd26 - {1'b0, p};
        return s[4:0];
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    assign cfg_write = (state == IDLE) && cfg_we;
    assign accept    = (state == IDLE) && in_valid && !cfg_we;
    assign cfg_val   = (cfg_data >= 5'd26) ? 5'd0 : cfg_data;
    // Letters keep the data register in 0..25, so a value of 26+ marks a bypass code
    assign bypass    = (data >= 5'd26);
    assign in_pass   = (state != IDLE) && (state != DONE);
    assign step_mid  = (pos0 == 5'(NOTCH0)) || (pos1 == 5'(NOTCH1));
    assign step_slow = (pos1 == 5'(NOTCH1));
    assign r_adj     = (rot_out >= 5'd26) ? rot_out - 5'd26 : rot_out;

    assign in_ready  = (state == IDLE) && !cfg_we;
    assign out_valid = (state == DONE);
    assign out_char  = data;
    assign pos_out   = {pos2, pos1, pos0};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Pass sequencing and datapath drive; rot_out only feeds data_next
    always_comb begin
        state_next = state;
        rot_sel    = 2'd0;
        rot_dir    = 1'b0;
        rot_in     = 5'd0;
        cur_pos    = 5'd0;
        data_next  = data;
        case (state)
            IDLE: if (accept) state_next = F0;
            F0: begin
                rot_sel = 2'd0; cur_pos = pos0; state_next = F1;
            end
            F1: begin
                rot_sel = 2'd1; cur_pos = pos1; state_next = F2;
            end
            F2: begin
                rot_sel = 2'd2; cur_pos = pos2; state_next = REF;
            end
            REF: begin
                rot_sel = 2'd3; state_next = B2;
            end
            B2: begin
                rot_sel = 2'd2; rot_dir = 1'b1; cur_pos = pos2; state_next = B1;
            end
            B1: begin
                rot_sel = 2'd1; rot_dir = 1'b1; cur_pos = pos1; state_next = B0;
            end
            B0: begin
                rot_sel = 2'd0; rot_dir = 1'b1; cur_pos = pos0; state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state == REF) begin
            rot_in    = data;
            data_next = r_adj;
        end else if (in_pass) begin
            rot_in    = add26(data, cur_pos);
            data_next = sub26(r_adj, cur_pos);
        end
    end

    // Rotor positions: configuration writes in IDLE, odometer step on letter accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos0 <= 5'd0;
            pos1 <= 5'd0;
            pos2 <= 5'd0;
        end else if (cfg_write) begin
            case (cfg_addr)
                2'd0:    pos0 <= cfg_val;
                2'd1:    pos1 <= cfg_val;
                2'd2:    pos2 <= cfg_val;
                default: ;
            endcase
        end else if (accept && (in_char < 5'd26)) begin
            pos0 <= inc26(pos0);
            if (step_mid)  pos1 <= inc26(pos1);
            if (step_slow) pos2 <= inc26(pos2);
        end
    end

    // Data register: latch on accept, update per pass unless carrying a bypass code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     data <= 5'd0;
        else if (accept)                data <= in_char;
        else if (in_pass && !bypass)    data <= data_next;
    end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// tb/tb_enigma_step_ctrl.sv - directed self-checking bench for enigma_step_ctrl
module tb_enigma_step_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_char;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_char;
    logic        out_ready;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [4:0]  cfg_data;
    logic [14:0] pos_out;
    logic [1:0]  rot_sel;
    logic        rot_dir;
    logic [4:0]  rot_in;
    logic [4:0]  rot_out;

    int n_checks = 0;
    int n_fail   = 0;

    enigma_step_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
        .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pos_out(pos_out), .rot_sel(rot_sel), .rot_dir(rot_dir),
        .rot_in(rot_in), .rot_out(rot_out)
    );

    always #5 clk = ~clk;

    // Identity rotors, reflector maps x to 25-x
    always_comb begin
        rot_out = rot_in;
        if (rot_sel == 2'd3) rot_out = (rot_in <= 5'd25) ? 5'(5'd25 - rot_in) : 5'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [4:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [4:0] c);
        @(negedge clk);
        in_valid = 1'b1; in_char = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Walks the seven pass states and checks the sequence and the result
    task automatic run_pass(input string tag, input logic [4:0] rin0, input logic [4:0] exp_out);
        logic [1:0] sel_exp [7];
        logic       dir_exp [7];
        sel_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        dir_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk({tag, "_sel"}, rot_sel, sel_exp[k]);
            chk({tag, "_dir"}, rot_dir, dir_exp[k]);
            if (k == 0) begin
                chk({tag, "_rot_in_f0"}, rot_in, rin0);
                chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
            end
            if (k == 6) chk({tag, "_no_early_valid"}, out_valid, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_out_char"}, out_char, exp_out);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready_back"}, in_ready, 1'b1);
        chk({tag, "_out_valid_low"}, out_valid, 1'b0);
    endtask

    initial begin
        logic seen_valid;
        rst_n = 1'b0; in_valid = 1'b0; in_char = 5'd0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 5'd0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pos", pos_out, 15'd0);
        chk("rst_rot_sel", rot_sel, 2'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Pass sequencing: positions 0, char 0 -> fast steps to 1, result 25
        send(5'd0);
        chk("seq_pos", pos_out, 15'd1);
        run_pass("seq", 5'd1, 5'd25);
        handshake("seq");

        // Offset wrap: fast 24 -> 25, F0 drives (3+25) mod 26 = 2, result 22
        cfg_write(2'd0, 5'd24);
        send(5'd3);
        chk("wrap_pos", pos_out, 15'd25);
        run_pass("wrap", 5'd2, 5'd22);
        handshake("wrap");

        // Bypass code: no stepping, passes straight through
        send(5'd30);
        chk("byp_pos", pos_out, 15'd25);
        run_pass("byp", 5'd29, 5'd30);
        handshake("byp");
        chk("byp_pos_after", pos_out, 15'd25);

        // Backpressure: fast 25 -> 0, result 20; inputs ignored while in DONE
        send(5'd5);
        chk("bp_pos", pos_out, 15'd0);
        run_pass("bp", 5'd5, 5'd20);
        in_valid = 1'b1; in_char = 5'd1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 5'd7;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("bp_out_char_hold", out_char, 5'd20);
        chk("bp_out_valid_hold", out_valid, 1'b1);
        chk("bp_cfg_ignored", pos_out, 15'd0);
        in_valid = 1'b0; cfg_we = 1'b0;
        handshake("bp");

        // Config priority: write lands, character not accepted
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 5'd9; in_valid = 1'b1; in_char = 5'd2;
        #1 chk("prio_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("prio_write", pos_out, 15'd288);
        for (int k = 0; k < 8; k++) @(negedge clk);
        chk("prio_not_accepted", out_valid, 1'b0);
        chk("prio_still_idle", in_ready, 1'b1);
        cfg_write(2'd1, 5'd27);
        chk("cfg_clamp", pos_out, 15'd0);
        cfg_write(2'd3, 5'd5);
        chk("cfg_addr3", pos_out, 15'd0);

        // Double-step from (0,3,20)
        cfg_write(2'd0, 5'd20);
        cfg_write(2'd1, 5'd3);
        cfg_write(2'd2, 5'd0);
        send(5'd1);
        chk("ds_pos1", pos_out, 15'd117);
        run_pass("ds1", 5'd22, 5'd24);
        handshake("ds1");
        send(5'd2);
        chk("ds_pos2", pos_out, 15'd150);
        run_pass("ds2", 5'd24, 5'd23);
        handshake("ds2");
        send(5'd3);
        chk("ds_pos3", pos_out, 15'd1207);
        run_pass("ds3", 5'd0, 5'd22);
        handshake("ds3");

        // Reset mid-pass
        send(5'd4);
        chk("mr_pos", pos_out, 15'd1208);
        @(posedge clk); @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_out_char", out_char, 5'd0);
        chk("mr_pos0", pos_out, 15'd0);
        chk("mr_rot_sel", rot_sel, 2'd0);
        chk("mr_rot_dir", rot_dir, 1'b0);
        chk("mr_rot_in", rot_in, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_in_ready_after", in_ready, 1'b1);
        chk("mr_pos_after", pos_out, 15'd0);
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("mr_no_valid", seen_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
